// File: rtl/eth_tx_frame_arb.sv
// -----------------------------------------------------------------------------
// eth_tx_frame_arb
//
// Frame-atomic round-robin arbiter in front of the 1G MAC transmit AXI stream
// (8-bit, tx_clk domain). One upstream source (UDP engine, ARP responder,
// debug/ping, ...) is granted for a whole frame, first beat through tlast.
// The granted port's stream is routed combinationally to the MAC; there is no
// pipeline stage, so a request seen in IDLE reaches m_axis one cycle later.
//
// Optional watchdog, compiled in with the macro ETH_TX_ARB_WATCHDOG_EN:
// a source that stalls mid-frame for WATCHDOG_CYCLES consecutive cycles (with
// the MAC ready) has its frame terminated by a single bad beat (data 0, tlast,
// tuser); the rest of that source's frame is then drained and discarded.
// Without the macro the FSM is IDLE/XFER only and abort_count reads 0.
//
// Parameters
//   PORTS           number of requesters, 2..8
//   WATCHDOG_CYCLES stall cycles before abort, 2..65535 (watchdog build only)
//
// Ports
//   tx_clk, tx_rst          clock, asynchronous active-high reset
//   s_axis_t*               per-port source streams; port i data = [8i+7:8i]
//   m_axis_t*               stream to the MAC tx_axis input
//   grant                   index of the granted port, holds when idle
//   busy                    registered, high whenever the FSM is not IDLE
//   abort_count             saturating count of watchdog aborts
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high. A source must hold tvalid and its payload stable until the beat
// transfers; tready may depend combinationally on tvalid, never the reverse.
// -----------------------------------------------------------------------------
module eth_tx_frame_arb #(
   parameter int unsigned PORTS           = 2,
   parameter int unsigned WATCHDOG_CYCLES = 1024
) (
   input  logic                 tx_clk,
   input  logic                 tx_rst,
   input  logic [PORTS*8-1:0]   s_axis_tdata,
   input  logic [PORTS-1:0]     s_axis_tvalid,
   output logic [PORTS-1:0]     s_axis_tready,
   input  logic [PORTS-1:0]     s_axis_tlast,
   input  logic [PORTS-1:0]     s_axis_tuser,
   output logic [7:0]           m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tlast,
   output logic                 m_axis_tuser,
   output logic [2:0]           grant,
   output logic                 busy,
   output logic [15:0]          abort_count
);

`ifdef ETH_TX_ARB_WATCHDOG_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_XFER  = 2'd1,
      ST_ABORT = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;
`else
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;
`endif

   // ---------------------------------------------------------------------------
   // Registers. state_q is the FSM state and is the signal to probe when
   // following the arbiter from outside.
   // ---------------------------------------------------------------------------
   state_t     state_q, state_d;
   logic [2:0] grant_q, grant_d;
   logic [2:0] last_q,  last_d;
   logic       busy_q,  busy_d;

`ifdef ETH_TX_ARB_WATCHDOG_EN
   logic [15:0] stall_q,     stall_d;
   logic [15:0] abort_cnt_q, abort_cnt_d;
`else
   // WATCHDOG_CYCLES has no function in this build; fold it into a sink.
   logic unused_cfg;
   assign unused_cfg = ^32'(WATCHDOG_CYCLES);
`endif

   // ---------------------------------------------------------------------------
   // Granted-port selection: a one-hot decode of grant_q drives an AND-OR mux
   // so no variable-width index into the per-port vectors is needed.
   // ---------------------------------------------------------------------------
   logic [PORTS-1:0] port_onehot;
   logic [7:0]       sel_data;
   logic             sel_valid;
   logic             sel_last;
   logic             sel_user;

   always_comb begin
      port_onehot = '0;
      sel_data    = '0;
      sel_valid   = 1'b0;
      sel_last    = 1'b0;
      sel_user    = 1'b0;
      for (int i = 0; i < PORTS; i++) begin
         if (grant_q == 3'(i)) begin
            port_onehot[i] = 1'b1;
            sel_data       = s_axis_tdata[8*i +: 8];
            sel_valid      = s_axis_tvalid[i];
            sel_last       = s_axis_tlast[i];
            sel_user       = s_axis_tuser[i];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Round-robin winner. The search order last+1, last+2, ... with wrap is
   // split into two ascending passes: ports above last first, then the rest
   // (which ends with last itself, so the just-finished port ranks lowest).
   // ---------------------------------------------------------------------------
   logic [2:0] rr_win;
   logic       rr_hit;

   always_comb begin
      rr_win = '0;
      rr_hit = 1'b0;
      for (int i = 0; i < PORTS; i++) begin
         if (!rr_hit && s_axis_tvalid[i] && (3'(i) > last_q)) begin
            rr_win = 3'(i);
            rr_hit = 1'b1;
         end
      end
      for (int i = 0; i < PORTS; i++) begin
         if (!rr_hit && s_axis_tvalid[i]) begin
            rr_win = 3'(i);
            rr_hit = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_d        = last_q;
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = 1'b0;
      s_axis_tready = '0;
`ifdef ETH_TX_ARB_WATCHDOG_EN
      stall_d       = stall_q;
      abort_cnt_d   = abort_cnt_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (|s_axis_tvalid) begin
               grant_d = rr_win;
               state_d = ST_XFER;
            end
         end

         ST_XFER: begin
            m_axis_tdata  = sel_data;
            m_axis_tvalid = sel_valid;
            m_axis_tlast  = sel_last;
            m_axis_tuser  = sel_user;
            s_axis_tready = port_onehot & {PORTS{m_axis_tready}};
            if (sel_valid && m_axis_tready) begin
`ifdef ETH_TX_ARB_WATCHDOG_EN
               stall_d = '0;
`endif
               if (sel_last) begin
                  last_d  = grant_q;
                  state_d = ST_IDLE;
               end
            end
`ifdef ETH_TX_ARB_WATCHDOG_EN
            // Only source-side idling counts: MAC backpressure holds the count.
            // The cycle that would bring the count to WATCHDOG_CYCLES moves
            // straight to ABORT, so the terminator follows the last stalled
            // cycle directly.
            else if (m_axis_tready) begin
               if (stall_q == 16'(WATCHDOG_CYCLES - 1)) begin
                  stall_d = '0;
                  state_d = ST_ABORT;
               end else begin
                  stall_d = stall_q + 16'd1;
               end
            end
`endif
         end

`ifdef ETH_TX_ARB_WATCHDOG_EN
         ST_ABORT: begin
            // Terminator beat closes the frame on the MAC side as bad.
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = 1'b1;
            m_axis_tuser  = 1'b1;
            if (m_axis_tready) begin
               if (abort_cnt_q != 16'hFFFF) begin
                  abort_cnt_d = abort_cnt_q + 16'd1;
               end
               last_d  = grant_q;
               state_d = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            // Swallow the rest of the stalled frame so the source resyncs on
            // a frame boundary.
            s_axis_tready = port_onehot;
            if (sel_valid && sel_last) begin
               state_d = ST_IDLE;
            end
         end
`endif

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge tx_clk or posedge tx_rst) begin
      if (tx_rst) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         last_q      <= 3'(PORTS - 1);
         busy_q      <= 1'b0;
`ifdef ETH_TX_ARB_WATCHDOG_EN
         stall_q     <= '0;
         abort_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         busy_q      <= busy_d;
`ifdef ETH_TX_ARB_WATCHDOG_EN
         stall_q     <= stall_d;
         abort_cnt_q <= abort_cnt_d;
`endif
      end
   end

   assign grant = grant_q;
   assign busy  = busy_q;
`ifdef ETH_TX_ARB_WATCHDOG_EN
   assign abort_count = abort_cnt_q;
`else
   assign abort_count = '0;
`endif

endmodule

// File: tb/tb_eth_tx_frame_arb.sv
// -----------------------------------------------------------------------------
// tb_eth_tx_frame_arb
//
// Per-port drivers replay queued beats (with optional idle gaps) onto the
// source streams. Every queued beat is also pushed to that port's expected
// queue. A negedge monitor keeps a frame-level reference model (round-robin
// search from last+1, one bubble between frames, watchdog abort after the
// configured number of ready-but-empty cycles) and pops/compares each beat the
// MAC accepts. Directed phases add checks on order, spacing and counters.
// -----------------------------------------------------------------------------
module tb_eth_tx_frame_arb;

   localparam int NP = 3;
   localparam int WD = 8;

   // ---------------- clock / reset ----------------
   logic tx_clk = 1'b0;
   logic tx_rst = 1'b1;
   always #5 tx_clk = ~tx_clk;

   int cyc = 0;
   always @(posedge tx_clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic [NP*8-1:0] s_tdata;
   logic [NP-1:0]   s_tvalid, s_tready, s_tlast, s_tuser;
   logic [7:0]      m_tdata;
   logic            m_tvalid, m_tready, m_tlast, m_tuser;
   logic [2:0]      grant;
   logic            busy;
   logic [15:0]     abort_count;

   eth_tx_frame_arb #(.PORTS(NP), .WATCHDOG_CYCLES(WD)) dut (
      .tx_clk        (tx_clk),
      .tx_rst        (tx_rst),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tlast  (s_tlast),
      .s_axis_tuser  (s_tuser),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tlast  (m_tlast),
      .m_axis_tuser  (m_tuser),
      .grant         (grant),
      .busy          (busy),
      .abort_count   (abort_count)
   );

   // ---------------- checking bookkeeping ----------------
   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- stimulus queues / driver ----------------
   typedef struct packed {
      logic [7:0] gap;
      logic       user;
      logic       last;
      logic [7:0] data;
   } beat_t;

   beat_t      stim_q [NP][$];
   logic [9:0] exp_q  [NP][$];   // {user, last, data}
   int         wait_cnt [NP];
   logic [NP-1:0] hs;            // source handshakes seen in the cycle just ended
   int         rdy_mode = 0;     // 0 always ready, 1 toggle, 2 random

   task automatic add_beat(input int p, input logic [7:0] d, input logic l,
                           input logic u, input int gap);
      beat_t b;
      b.data = d;
      b.last = l;
      b.user = u;
      b.gap  = 8'(gap);
      stim_q[p].push_back(b);
      exp_q[p].push_back({u, l, d});
   endtask

   task automatic push_frame(input int p, input int len, input int first_gap,
                             input int mid_gap_max, input logic bad);
      for (int i = 0; i < len; i++) begin
         int   g;
         logic u;
         logic l;
         l = (i == len - 1);
         g = (i == 0) ? first_gap : $urandom_range(0, mid_gap_max);
         if (i != 0 && mid_gap_max > 0 && $urandom_range(0, 9) == 0) g = 12;
         u = l ? bad : ((mid_gap_max > 0) ? 1'($urandom_range(0, 1)) : 1'b0);
         add_beat(p, 8'($urandom_range(0, 255)), l, u, g);
      end
   endtask

   initial begin
      beat_t b;
      s_tdata  = '0;
      s_tvalid = '0;
      s_tlast  = '0;
      s_tuser  = '0;
      m_tready = 1'b1;
      for (int p = 0; p < NP; p++) wait_cnt[p] = 0;
      forever begin
         @(posedge tx_clk);
         #1;
         for (int p = 0; p < NP; p++) begin
            if (s_tvalid[p] && hs[p]) s_tvalid[p] = 1'b0;
            if (!s_tvalid[p] && stim_q[p].size() > 0) begin
               if (wait_cnt[p] < int'(stim_q[p][0].gap)) begin
                  wait_cnt[p]++;
               end else begin
                  b = stim_q[p].pop_front();
                  s_tdata[8*p +: 8] = b.data;
                  s_tlast[p]        = b.last;
                  s_tuser[p]        = b.user;
                  s_tvalid[p]       = 1'b1;
                  wait_cnt[p]       = 0;
               end
            end
         end
         case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // ---------------- reference model + monitor ----------------
   typedef enum int {M_IDLE, M_ACT, M_ABT, M_DRN} mmode_t;
   mmode_t mmode = M_IDLE;
   int     m_last = NP - 1;
   int     m_win = 0;
   int     m_sc = 0;
   int     abort_exp = 0;
   bit     first_beat = 1'b0;
   int     req_cyc = 0;
   int     last_hs_cyc = 0;
   int     abort_cyc = 0;
   int     start_log[$];
   int     start_cyc[$];
   int     lat_q[$];

   function automatic int rr_pick(input int last, input logic [NP-1:0] v);
      int idx;
      for (int k = 1; k <= NP; k++) begin
         idx = (last + k) % NP;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   always @(negedge tx_clk) begin
      logic [9:0]    e;
      logic [NP-1:0] one;
      for (int p = 0; p < NP; p++) hs[p] = s_tvalid[p] && s_tready[p];
      if (tx_rst) begin
         mmode     = M_IDLE;
         m_last    = NP - 1;
         m_sc      = 0;
         abort_exp = 0;
      end else begin
         one = NP'(1) << m_win;
         chk("busy", 32'(busy), 32'(mmode != M_IDLE));
         chk("abort_count", 32'(abort_count), 32'(abort_exp));
         case (mmode)
            M_IDLE: begin
               chk("idle_m_tvalid", 32'(m_tvalid), 0);
               chk("idle_s_tready", 32'(s_tready), 0);
               if (|s_tvalid) begin
                  m_win      = rr_pick(m_last, s_tvalid);
                  mmode      = M_ACT;
                  m_sc       = 0;
                  first_beat = 1'b1;
                  req_cyc    = cyc;
               end
            end
            M_ACT: begin
               chk("grant", 32'(grant), 32'(m_win));
               chk("xfer_m_tvalid", 32'(m_tvalid), 32'(s_tvalid[m_win]));
               chk("xfer_s_tready", 32'(s_tready), m_tready ? 32'(one) : 0);
               if (s_tvalid[m_win] && m_tready) begin
                  if (first_beat) begin
                     start_log.push_back(m_win);
                     start_cyc.push_back(cyc);
                     lat_q.push_back(cyc - req_cyc);
                     first_beat = 1'b0;
                  end
                  last_hs_cyc = cyc;
                  m_sc = 0;
                  if (exp_q[m_win].size() == 0) begin
                     chk("exp_underflow", 1, 0);
                  end else begin
                     e = exp_q[m_win].pop_front();
                     chk("m_tdata", 32'(m_tdata), 32'(e[7:0]));
                     chk("m_tlast", 32'(m_tlast), 32'(e[8]));
                     chk("m_tuser", 32'(m_tuser), 32'(e[9]));
                     if (e[8]) begin
                        m_last = m_win;
                        mmode  = M_IDLE;
                     end
                  end
               end else if (m_tready) begin
                  m_sc++;
`ifdef ETH_TX_ARB_WATCHDOG_EN
                  if (m_sc == WD) mmode = M_ABT;
`endif
               end
            end
            M_ABT: begin
               chk("abort_m_tvalid", 32'(m_tvalid), 1);
               chk("abort_m_tdata", 32'(m_tdata), 0);
               chk("abort_m_tlast", 32'(m_tlast), 1);
               chk("abort_m_tuser", 32'(m_tuser), 1);
               chk("abort_s_tready", 32'(s_tready), 0);
               if (m_tready) begin
                  if (abort_exp < 65535) abort_exp++;
                  abort_cyc = cyc;
                  m_last    = m_win;
                  mmode     = M_DRN;
                  // The rest of the stalled frame never reaches the MAC.
                  while (exp_q[m_win].size() > 0) begin
                     e = exp_q[m_win].pop_front();
                     if (e[8]) break;
                  end
               end
            end
            default: begin
               chk("drain_m_tvalid", 32'(m_tvalid), 0);
               chk("drain_s_tready", 32'(s_tready), 32'(one));
               if (s_tvalid[m_win] && s_tlast[m_win]) mmode = M_IDLE;
            end
         endcase
      end
   end

   // ---------------- phase helpers ----------------
   function automatic bit all_quiet();
      for (int p = 0; p < NP; p++)
         if (stim_q[p].size() != 0 || exp_q[p].size() != 0) return 1'b0;
      if (s_tvalid != '0) return 1'b0;
      return (mmode == M_IDLE);
   endfunction

   task automatic wait_idle(input string name, input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge tx_clk);
         #2;
         if (all_quiet()) begin
            done = 1'b1;
            break;
         end
      end
      chk(name, 32'(done), 1);
      repeat (3) @(negedge tx_clk);
      #2;
   endtask

   task automatic clear_logs();
      start_log.delete();
      start_cyc.delete();
      lat_q.delete();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int order[6];
      order = '{0, 1, 2, 0, 1, 2};

      repeat (3) @(posedge tx_clk);
      @(negedge tx_clk);
      tx_rst = 1'b0;
      #1;
      chk("rst_s_tready", 32'(s_tready), 0);
      chk("rst_m_tvalid", 32'(m_tvalid), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_abort_count", 32'(abort_count), 0);
      chk("rst_busy", 32'(busy), 0);
      repeat (2) @(negedge tx_clk);
      #2;

      // Fairness: every port holds two back-to-back 4-beat frames.
      clear_logs();
      rdy_mode = 0;
      for (int r = 0; r < 2; r++)
         for (int p = 0; p < NP; p++) push_frame(p, 4, 0, 0, 1'b0);
      wait_idle("fair_timeout", 400);
      chk("fair_frames", 32'(start_log.size()), 6);
      for (int i = 0; i < 6 && i < start_log.size(); i++)
         chk("fair_order", 32'(start_log[i]), 32'(order[i]));
      for (int i = 1; i < start_cyc.size(); i++)
         chk("fair_spacing", 32'(start_cyc[i] - start_cyc[i-1]), 5);

      // Backpressure: 64-byte frame on port 1, MAC ready toggling.
      clear_logs();
      rdy_mode = 1;
      push_frame(1, 64, 0, 0, 1'b0);
      wait_idle("bp_timeout", 800);
      chk("bp_no_abort", 32'(abort_count), 0);
      rdy_mode = 0;

      // Bad frame: tuser on the last beat passes through.
      clear_logs();
      push_frame(0, 10, 0, 0, 1'b1);
      wait_idle("bad_timeout", 200);
      chk("bad_no_abort", 32'(abort_count), 0);

`ifdef ETH_TX_ARB_WATCHDOG_EN
      // Watchdog: port 2 stalls after 3 beats; port 0 requests meanwhile.
      clear_logs();
      for (int i = 0; i < 8; i++)
         add_beat(2, 8'(8'h40 + i), (i == 7), 1'b0, (i == 3) ? 20 : 0);
      push_frame(0, 3, 6, 0, 1'b0);
      wait_idle("wd_timeout", 400);
      chk("wd_abort_count", 32'(abort_count), 1);
      chk("wd_stall_len", 32'(abort_cyc - last_hs_cyc), 32'(WD + 1));
      chk("wd_frames", 32'(start_log.size()), 2);
      if (start_log.size() == 2) begin
         chk("wd_first_port", 32'(start_log[0]), 2);
         chk("wd_next_port", 32'(start_log[1]), 0);
      end
`endif

      // Single-beat frames from ports 0 and 1 in the same cycle, fresh reset.
      @(negedge tx_clk);
      tx_rst = 1'b1;
      @(negedge tx_clk);
      tx_rst = 1'b0;
      #2;
      clear_logs();
      push_frame(0, 1, 0, 0, 1'b0);
      push_frame(1, 1, 0, 0, 1'b0);
      wait_idle("single_timeout", 100);
      chk("single_frames", 32'(start_log.size()), 2);
      if (start_log.size() == 2) begin
         chk("single_port0", 32'(start_log[0]), 0);
         chk("single_port1", 32'(start_log[1]), 1);
         chk("single_latency", 32'(lat_q[0]), 1);
         chk("single_gap", 32'(start_cyc[1] - start_cyc[0]), 2);
      end

      // Randomized traffic: random ports, lengths, gaps, tuser, MAC ready.
      clear_logs();
      rdy_mode = 2;
      for (int f = 0; f < 40; f++)
         push_frame($urandom_range(0, NP - 1), $urandom_range(1, 8),
                    $urandom_range(0, 4), 2, 1'($urandom_range(0, 1)));
      wait_idle("rand_timeout", 20000);
      rdy_mode = 0;

      for (int p = 0; p < NP; p++)
         chk("exp_q_empty", 32'(exp_q[p].size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "global timeout");
   end

endmodule
